// File: rtl/coin_change_dispenser_pkg.sv
// Shared definitions for the coin change dispenser: denomination indices, values, FSM encoding.
package coin_change_dispenser_pkg;

   localparam int NUM_COINS   = 4;
   localparam int IDX_NICKEL  = 0;
   localparam int IDX_DIME    = 1;
   localparam int IDX_QUARTER = 2;
   localparam int IDX_DOLLAR  = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_PULSE  = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   function automatic int unsigned coin_value(input logic [1:0] idx);
      case (idx)
         2'd3:    coin_value = 100;
         2'd2:    coin_value = 25;
         2'd1:    coin_value = 10;
         default: coin_value = 5;
      endcase
   endfunction

endpackage

// File: rtl/coin_change_dispenser_pulse_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module coin_change_dispenser_pulse_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays out change one coin at a time, largest denomination first, falling back on empty tubes.
// state  | meaning
// IDLE   | waiting for a change request (ready)
// SELECT | pick the next coin from remaining amount and stock
// PULSE  | selected solenoid energised
// GAP    | all solenoids off between coins
// DONE   | one-cycle completion, short status latched
module coin_change_dispenser
   import coin_change_dispenser_pkg::*;
#(
   parameter int AMT_W        = 10,
   parameter int STOCK_W      = 8,
   parameter int INIT_STOCK   = 20,
   parameter int PULSE_CYCLES = 5_000_000,
   parameter int GAP_CYCLES   = 5_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             change_valid,
   input  logic [AMT_W-1:0] change_amt,
   output logic             change_ready,
   input  logic             restock,
   output logic             eject_dollar,
   output logic             eject_quarter,
   output logic             eject_dime,
   output logic             eject_nickel,
   output logic             busy,
   output logic             done,
   output logic             short_flag,
   output logic [AMT_W-1:0] short_amt,
   output logic [3:0]       tube_empty
);

   localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

   state_t             state_q, state_d;
   logic [AMT_W-1:0]   remaining_q, remaining_d;
   logic [STOCK_W-1:0] stock_q [NUM_COINS];
   logic [STOCK_W-1:0] stock_d [NUM_COINS];
   logic [1:0]         coin_q, coin_d;
   logic [3:0]         eject_q, eject_d;
   logic               short_flag_q, short_flag_d;
   logic [AMT_W-1:0]   short_amt_q, short_amt_d;

   logic               found;
   logic [1:0]         pick;
   logic               timer_load;
   logic [CNT_W-1:0]   timer_val;
   logic               timer_expired;

   coin_change_dispenser_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .expired  (timer_expired)
   );

   // Largest denomination that fits the remainder and still has a coin in its tube.
   always_comb begin
      found = 1'b0;
      pick  = 2'd0;
      for (int i = NUM_COINS - 1; i >= 0; i--) begin
         if (!found && (remaining_q >= AMT_W'(coin_value(2'(i)))) && (stock_q[i] != '0)) begin
            found = 1'b1;
            pick  = 2'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (change_valid) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (found) begin
               state_d    = ST_PULSE;
               timer_load = 1'b1;
               timer_val  = PULSE_LOAD;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_PULSE: begin
            if (timer_expired) begin
               state_d    = ST_GAP;
               timer_load = 1'b1;
               timer_val  = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (timer_expired) state_d = ST_SELECT;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      remaining_d  = remaining_q;
      coin_d       = coin_q;
      short_flag_d = short_flag_q;
      short_amt_d  = short_amt_q;
      for (int i = 0; i < NUM_COINS; i++) stock_d[i] = stock_q[i];

      if (state_q == ST_IDLE && change_valid) begin
         remaining_d  = change_amt;
         short_flag_d = 1'b0;
         short_amt_d  = '0;
      end

      if (state_q == ST_SELECT) begin
         if (found) begin
            remaining_d   = remaining_q - AMT_W'(coin_value(pick));
            stock_d[pick] = stock_q[pick] - STOCK_W'(1);
            coin_d        = pick;
         end else if (remaining_q != '0) begin
            short_flag_d = 1'b1;
            short_amt_d  = remaining_q;
         end
      end

      // Refill overrides a same-cycle decrement.
      if (restock) begin
         for (int i = 0; i < NUM_COINS; i++) stock_d[i] = STOCK_W'(INIT_STOCK);
      end

      eject_d = (state_d == ST_PULSE) ? (4'b0001 << coin_d) : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining_q  <= '0;
         coin_q       <= 2'd0;
         eject_q      <= 4'b0000;
         short_flag_q <= 1'b0;
         short_amt_q  <= '0;
         for (int i = 0; i < NUM_COINS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
      end else begin
         remaining_q  <= remaining_d;
         coin_q       <= coin_d;
         eject_q      <= eject_d;
         short_flag_q <= short_flag_d;
         short_amt_q  <= short_amt_d;
         for (int i = 0; i < NUM_COINS; i++) stock_q[i] <= stock_d[i];
      end
   end

   always_comb begin
      change_ready  = (state_q == ST_IDLE);
      busy          = (state_q != ST_IDLE);
      done          = (state_q == ST_DONE);
      eject_dollar  = eject_q[IDX_DOLLAR];
      eject_quarter = eject_q[IDX_QUARTER];
      eject_dime    = eject_q[IDX_DIME];
      eject_nickel  = eject_q[IDX_NICKEL];
      short_flag    = short_flag_q;
      short_amt     = short_amt_q;
      for (int i = 0; i < NUM_COINS; i++) tube_empty[i] = (stock_q[i] == '0);
   end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Randomized and directed bench for coin_change_dispenser against a timeline-based payout model.
module tb_coin_change_dispenser;

   localparam int AMT_W = 10;
   localparam int INIT  = 4;
   localparam int PULSE = 2;
   localparam int GAP   = 1;
   localparam int STEP  = 1 + PULSE + GAP;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             change_valid = 1'b0;
   logic [AMT_W-1:0] change_amt = '0;
   logic             change_ready;
   logic             restock = 1'b0;
   logic             eject_dollar, eject_quarter, eject_dime, eject_nickel;
   logic             busy, done, short_flag;
   logic [AMT_W-1:0] short_amt;
   logic [3:0]       tube_empty;

   coin_change_dispenser #(
      .AMT_W(AMT_W), .STOCK_W(8), .INIT_STOCK(INIT),
      .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .change_valid(change_valid), .change_amt(change_amt),
      .change_ready(change_ready), .restock(restock),
      .eject_dollar(eject_dollar), .eject_quarter(eject_quarter),
      .eject_dime(eject_dime), .eject_nickel(eject_nickel),
      .busy(busy), .done(done), .short_flag(short_flag), .short_amt(short_amt),
      .tube_empty(tube_empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model: coin values by index (0 nickel .. 3 dollar)
   int   vals [4] = '{5, 10, 25, 100};
   int   m_stock [4];
   bit   m_active;
   int   m_t;
   int   m_rem;
   int   m_done_rel;
   int   m_coins [$];
   bit   m_short;
   int   m_short_amt;

   int   dut_seq [$];
   logic [3:0] prev_ej = 4'b0;
   int   last_done_cyc = -1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_stock[i] = INIT;
      m_active    = 1'b0;
      m_short     = 1'b0;
      m_short_amt = 0;
      m_coins.delete();
   endtask

   task automatic step(input logic v, input logic [AMT_W-1:0] amt, input logic rs);
      int rel;
      int k;
      int ph;
      bit was_idle;
      bit f;
      bit exp_busy;
      logic [3:0] ej_exp;
      logic [3:0] ej_act;
      logic [3:0] te_exp;
      @(negedge clk);
      cyc++;
      rel = cyc - m_t;
      ej_exp = 4'b0;
      if (m_active && rel >= 2) begin
         k  = (rel - 2) / STEP;
         ph = (rel - 2) % STEP;
         if (k < m_coins.size() && ph < PULSE) ej_exp[m_coins[k]] = 1'b1;
      end
      ej_act = {eject_dollar, eject_quarter, eject_dime, eject_nickel};
      exp_busy = m_active && rel >= 1;
      for (int i = 0; i < 4; i++) te_exp[i] = (m_stock[i] == 0);
      chk("eject", int'(ej_act), int'(ej_exp));
      chk("busy", int'(busy), int'(exp_busy));
      chk("ready", int'(change_ready), int'(!exp_busy));
      chk("done", int'(done), int'(m_active && rel == m_done_rel));
      chk("short_flag", int'(short_flag), int'(m_short));
      chk("short_amt", int'(short_amt), m_short_amt);
      chk("tube_empty", int'(tube_empty), int'(te_exp));
      if (ej_act != 4'b0 && prev_ej == 4'b0) begin
         for (int i = 0; i < 4; i++) if (ej_act[i]) dut_seq.push_back(i);
      end
      prev_ej = ej_act;
      if (done) last_done_cyc = cyc;

      change_valid = v;
      change_amt   = amt;
      restock      = rs;

      was_idle = !m_active;
      if (m_active) begin
         if (rel == m_done_rel) begin
            m_active = 1'b0;
         end else if (rel == 1 + m_coins.size() * STEP) begin
            f = 1'b0;
            for (int i = 3; i >= 0; i--) begin
               if (!f && m_rem >= vals[i] && m_stock[i] > 0) begin
                  f = 1'b1;
                  m_rem -= vals[i];
                  m_stock[i]--;
                  m_coins.push_back(i);
               end
            end
            if (!f) begin
               m_done_rel  = rel + 1;
               m_short     = (m_rem != 0);
               m_short_amt = m_rem;
            end
         end
      end
      if (was_idle && v && rst_n) begin
         m_active    = 1'b1;
         m_t         = cyc;
         m_rem       = int'(amt);
         m_done_rel  = 1 << 30;
         m_short     = 1'b0;
         m_short_amt = 0;
         m_coins.delete();
      end
      if (rs) for (int i = 0; i < 4; i++) m_stock[i] = INIT;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_active && n < 200) begin
         step(1'b0, '0, 1'b0);
         n++;
      end
      if (m_active) chk("request_timeout", 1, 0);
      step(1'b0, '0, 1'b0);
   endtask

   task automatic do_req(input int amt, output int acc);
      dut_seq.delete();
      step(1'b1, AMT_W'(amt), 1'b0);
      acc = cyc;
      wait_idle();
   endtask

   initial begin
      int acc;
      logic [AMT_W-1:0] ramt;
      model_reset();
      m_t = 0;
      rst_n = 1'b0;
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b0);

      // 140c from full tubes: one of each coin, largest first
      do_req(140, acc);
      chk("t1_ncoins", dut_seq.size(), 4);
      if (dut_seq.size() == 4) begin
         chk("t1_c0", dut_seq[0], 3);
         chk("t1_c1", dut_seq[1], 2);
         chk("t1_c2", dut_seq[2], 1);
         chk("t1_c3", dut_seq[3], 0);
      end
      chk("t1_short", int'(short_flag), 0);

      // zero amount: done two cycles after accept, no coins
      do_req(0, acc);
      chk("t2_latency", last_done_cyc - acc, 2);
      chk("t2_ncoins", dut_seq.size(), 0);

      // 95c twice after restock: second request runs tubes dry and is 30c short
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      do_req(95, acc);
      chk("t3a_ncoins", dut_seq.size(), 5);
      do_req(95, acc);
      chk("t3_short_flag", int'(short_flag), 1);
      chk("t3_short_amt", int'(short_amt), 30);
      chk("t3_tube_empty", int'(tube_empty), 7);

      // 7c: one nickel, 2c residue
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      do_req(7, acc);
      chk("t4_ncoins", dut_seq.size(), 1);
      if (dut_seq.size() == 1) chk("t4_coin", dut_seq[0], 0);
      chk("t4_short_amt", int'(short_amt), 2);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("t4_restock", int'(tube_empty), 0);

      // requests while busy are dropped; restock coincident with the second SELECT
      dut_seq.delete();
      step(1'b1, AMT_W'(140), 1'b0);
      acc = cyc;
      for (int n = 0; n < 200 && m_active; n++) begin
         step(1'b1, AMT_W'(5), (cyc + 1 - acc) == 1 + STEP);
      end
      if (m_active) chk("t6_timeout", 1, 0);
      step(1'b0, '0, 1'b0);
      chk("t6_ncoins", dut_seq.size(), 4);
      step(1'b0, '0, 1'b0);

      // reset during the second pulse of 140c
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      step(1'b1, AMT_W'(140), 1'b0);
      acc = cyc;
      while (cyc - acc < 2 + STEP) step(1'b0, '0, 1'b0);
      chk("t5_pre_quarter", int'(eject_quarter), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_eject", int'({eject_dollar, eject_quarter, eject_dime, eject_nickel}), 0);
      chk("t5_rst_busy", int'(busy), 0);
      model_reset();
      step(1'b0, '0, 1'b0);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b0);
      do_req(25, acc);
      chk("t5_ncoins", dut_seq.size(), 1);
      if (dut_seq.size() == 1) chk("t5_coin", dut_seq[0], 2);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 1) == 0) ramt = AMT_W'($urandom_range(0, 1023));
         else ramt = AMT_W'($urandom_range(0, 60) * 5 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0));
         step(m_active ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0),
              ramt, $urandom_range(0, 39) == 0);
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
